// File: rtl/lcc_reply_collector.sv
// Collects the 4-byte LCC reply (echo, data_hi, data_lo, xor checksum) after each request,
// validates it and reports either the payload word or a classified, counted error.
module lcc_reply_collector #(
  parameter logic [19:0] TIMEOUT = 20'd80640,
  parameter logic [7:0]  ERR_SAT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iRqStart,
  input  logic [7:0]  iRqNum,
  input  logic [7:0]  iData,
  input  logic        iValid,
  output logic [15:0] oWord,
  output logic [7:0]  oNum,
  output logic        oStrobe,
  output logic        oErr,
  output logic [1:0]  oErrCode,
  output logic [7:0]  oErrCnt,
  output logic        oBusy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RECEIVE    = 2'd2,
    CHECK      = 2'd3
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_ECHO    = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  state_t      state_r;
  logic [7:0]  num_r;
  logic [1:0]  idx_r;
  logic [19:0] timer_r;
  logic [7:0]  frame_r [4];

  function automatic logic [7:0] frame_csum(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == ERR_SAT) ? cnt : cnt + 8'd1;
  endfunction

  // Reply FSM with registered outputs; a new request always wins over a byte or a check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      num_r    <= 8'd0;
      idx_r    <= 2'd0;
      timer_r  <= 20'd0;
      for (int i = 0; i < 4; i++) frame_r[i] <= 8'd0;
      oWord    <= 16'd0;
      oNum     <= 8'd0;
      oStrobe  <= 1'b0;
      oErr     <= 1'b0;
      oErrCode <= 2'd0;
      oErrCnt  <= 8'd0;
      oBusy    <= 1'b0;
    end else begin
      oStrobe <= 1'b0;
      oErr    <= 1'b0;
      if (iRqStart) begin
        // Any request outside IDLE aborts whatever frame was pending.
        if (state_r != IDLE) begin
          oErr     <= 1'b1;
          oErrCode <= ERR_OVERRUN;
          oErrCnt  <= sat_inc(oErrCnt);
        end
        num_r   <= iRqNum;
        idx_r   <= 2'd0;
        timer_r <= 20'd0;
        state_r <= WAIT_FIRST;
        oBusy   <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            oBusy <= 1'b0;
          end
          WAIT_FIRST, RECEIVE: begin
            if (iValid) begin
              frame_r[idx_r] <= iData;
              idx_r          <= idx_r + 2'd1;
              timer_r        <= 20'd0;
              state_r        <= (idx_r == 2'd3) ? CHECK : RECEIVE;
            end else if (timer_r == TIMEOUT - 20'd1) begin
              oErr     <= 1'b1;
              oErrCode <= ERR_TIMEOUT;
              oErrCnt  <= sat_inc(oErrCnt);
              state_r  <= IDLE;
              oBusy    <= 1'b0;
            end else begin
              timer_r <= timer_r + 20'd1;
            end
          end
          CHECK: begin
            state_r <= IDLE;
            oBusy   <= 1'b0;
            // Echo failure is reported even when the checksum is also wrong.
            if (frame_r[0] != num_r) begin
              oErr     <= 1'b1;
              oErrCode <= ERR_ECHO;
              oErrCnt  <= sat_inc(oErrCnt);
            end else if (frame_r[3] != frame_csum(frame_r[0], frame_r[1], frame_r[2])) begin
              oErr     <= 1'b1;
              oErrCode <= ERR_CSUM;
              oErrCnt  <= sat_inc(oErrCnt);
            end else begin
              oStrobe <= 1'b1;
              oWord   <= {frame_r[1], frame_r[2]};
              oNum    <= num_r;
            end
          end
          default: begin
            state_r <= IDLE;
            oBusy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
